aq_f_spsram_ctrl: RTL
=====================

// Module: aq_f_spsram_ctrl
// PURPOSE
//  Initiator-side controller for an active-low single-port SRAM macro.
//  Macro port set: A, CEN, GWEN, bit-WEN, D, Q. Read data is valid one cycle after
//  the read issue, and the macro holds its address while CEN=1.
//  Converts a valid/ready request stream into macro cycles and returns read data
//  through a valid/ready response port. It also runs a hardware fill sequence
//  that writes INIT_VAL to every entry. It sits between a cache/TLB pipeline and
//  its data or tag array.
// PARAMETERS
//  ADDR_WIDTH  10       macro address width; depth = 2**ADDR_WIDTH
//  DATA_WIDTH  64       macro data width
//  INIT_VAL    64'h0    fill value written by the init sequence
//  AUTO_INIT   1        1: start the init sequence on reset release; 0: go straight to IDLE
// PORTS
//  CLK        in   1    clock; all state updates on the rising edge
//  RST        in   1    synchronous reset, active-high
//  req_vld    in   1    request valid
//  req_rdy    out  1    request accepted when req_vld&req_rdy
//  req_wr     in   1    1=write, 0=read
//  req_addr   in   AW   request address
//  req_wdata  in   DW   write data
//  req_wmask  in   DW   per-bit write enable, active-high
//  rsp_vld    out  1    read data valid
//  rsp_rdy    in   1    response consumed when rsp_vld&rsp_rdy
//  rsp_rdata  out  DW   read data (combinational from sram_q)
//  init_req   in   1    single-cycle pulse: request a fill
//  init_busy  out  1    fill sequence in progress
//  init_done  out  1    one-cycle pulse after the last fill write
//  sram_a     out  AW   macro address
//  sram_cen   out  1    macro chip enable, active-low
//  sram_gwen  out  1    macro global write enable, active-low
//  sram_wen   out  DW   macro bit write enable, active-low = ~req_wmask
//  sram_d     out  DW   macro write data
//  sram_q     in   DW   macro read data
// BEHAVIOUR
//  Clock and reset: one clock, CLK. RST is synchronous and active-high.
//  State machine states: IDLE, INIT.
//   - Reset state is INIT when AUTO_INIT=1, IDLE otherwise.
//   - Reset state of registers: cnt=0, rd_pend=0, init_pend=0.
//  Output values while RST=1:
//   - sram_cen=1, sram_gwen=1, sram_wen=all-1, sram_a=0, sram_d=0
//   - req_rdy=0, rsp_vld=0, init_busy=0, init_done=0
//  Outputs are combinational from state and request; the cycle of acceptance is the macro cycle.
//  req_rdy = IDLE & !init_pend & !init_req & (!rd_pend | rsp_rdy).
//  Accepted request drives:
//   - sram_cen=0, sram_a=req_addr
//   - write: sram_gwen=0, sram_wen=~req_wmask, sram_d=req_wdata
//   - read: sram_gwen=1, sram_wen=all-1
//  Read issued at cycle N:
//   - rd_pend=1 from N+1; rsp_vld=rd_pend; rsp_rdata=sram_q
//   - the macro holds A, so Q stays stable across stalls.
//   - rd_pend clears on rsp_rdy, unless another read is accepted in the same cycle (back-to-back, 1 read/cycle).
//  Writes produce no response. A write is accepted in the cycle a pending read
//  drains (rsp_rdy=1); a write never overlaps an undrained read.
//  Idle: sram_cen=1, sram_gwen=1, sram_wen=all-1, sram_a/sram_d=0.
//  init_req in IDLE:
//   - if !rd_pend, or rd_pend & rsp_rdy: enter INIT next cycle.
//   - otherwise set init_pend; enter INIT the cycle after the response drains.
//  init_req beats a same-cycle req_vld; the request is not accepted.
//  INIT state:
//   - sram_cen=0, sram_gwen=0, sram_wen=0, sram_a=cnt, sram_d=INIT_VAL, init_busy=1, req_rdy=0
//   - cnt increments each cycle
//   - at cnt=2**AW-1: cnt wraps to 0, go to IDLE, init_done=1 for exactly the next cycle
//   - fill lasts exactly 2**AW cycles; init_req while in INIT is ignored
//  RST mid-INIT: cnt returns to 0; fill restarts from address 0 if AUTO_INIT=1, else aborts to IDLE.
//  RST mid-read: the pending response is dropped and rsp_vld=0.
// TESTING
//  AUTO_INIT=1, AW=4:
//   - release RST -> sram_a counts 0..15 with cen=gwen=0
//   - init_busy high 16 cycles; init_done pulses once; then req_rdy=1
//  Write/read:
//   - write addr 5, data 64'hDEAD_BEEF_0123_4567, mask all-1; then read addr 5
//   - rsp_vld the cycle after the read issue; rsp_rdata=64'hDEAD_BEEF_0123_4567
//  Partial write:
//   - mask 64'h0000_0000_FFFF_FFFF, data all-1 to an entry holding 0
//   - read -> 64'h0000_0000_FFFF_FFFF
//  Back-pressure:
//   - read addr 3, rsp_rdy=0 for 4 cycles
//   - rsp_vld held, rsp_rdata stable, req_rdy=0, sram_cen=1 throughout
//   - rsp_rdy=1 with a new read addr 4 -> accepted the same cycle; the next response is addr 4's data
//  Streaming: 8 back-to-back reads with rsp_rdy=1 -> 8 responses in consecutive cycles, in order.
//  Init races:
//   - init_req during a stalled response -> INIT starts the cycle after rsp_rdy
//   - init_req together with req_vld -> request held off, fill runs, request accepted after init_done
//   - RST asserted mid-fill at cnt=7 -> fill restarts at 0

Source files
------------

// File: rtl/aq_f_spsram_ctrl.sv
// Request/response controller for an active-low single-port SRAM macro,
// with a hardware fill sequence that writes INIT_VAL to every entry.
module aq_f_spsram_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
  parameter bit                    AUTO_INIT  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  init_req,
  output logic                  init_busy,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StInit  = 1'b1;
  localparam logic [0:0] StReset = AUTO_INIT ? StInit : StIdle;

  localparam logic [ADDR_WIDTH-1:0] CntMax = {ADDR_WIDTH{1'b1}};

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  init_pend_q, init_pend_d;
  logic                  init_done_q, init_done_d;

  logic idle;
  logic drain_ok;
  logic acc;
  logic rd_acc;
  logic init_want;

  // The macro holds its last read word while CEN=1, so Q feeds the response directly.
  assign rsp_rdata = sram_q;

  always_comb begin
    idle      = (state_q == StIdle);
    drain_ok  = !rd_pend_q || rsp_rdy;
    init_want = init_req || init_pend_q;

    req_rdy   = !RST && idle && !init_pend_q && !init_req && drain_ok;
    acc       = req_vld && req_rdy;
    rd_acc    = acc && !req_wr;

    rsp_vld   = !RST && rd_pend_q;
    init_busy = !RST && !idle;
    init_done = !RST && init_done_q;

    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (!RST && !idle) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = cnt_q;
      sram_d    = INIT_VAL;
    end else if (acc) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
      if (req_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~req_wmask;
        sram_d    = req_wdata;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_pend_d   = rd_pend_q;
    init_pend_d = init_pend_q;
    init_done_d = 1'b0;

    if (idle) begin
      if (rd_acc) begin
        rd_pend_d = 1'b1;
      end else if (rsp_rdy) begin
        rd_pend_d = 1'b0;
      end
      // A fill waits for any undrained read response before it starts.
      if (init_want && drain_ok) begin
        state_d     = StInit;
        init_pend_d = 1'b0;
      end else if (init_want) begin
        init_pend_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CntMax) begin
        state_d     = StIdle;
        init_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StReset;
      cnt_q       <= '0;
      rd_pend_q   <= 1'b0;
      init_pend_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_pend_q   <= rd_pend_d;
      init_pend_q <= init_pend_d;
      init_done_q <= init_done_d;
    end
  end

endmodule
